// File: rtl/dct_pkg.sv
// dct_pkg: cosine tables, coefficient lookup and FSM state for dct_2d_stream.
// Tables hold a(u)*cos(k*pi/2N) at 16 fractional bits (COEF_WIDTH = 18).
package dct_pkg;

  typedef enum logic {LOAD, EMIT} state_t;

  localparam int COEF_FRAC = 16;

  localparam int A0_8 = 23170;
  localparam int A0_4 = 32768;

  function automatic int cos8(int k);
    int m;
    case (k)
      0: m = 32768;
      1: m = 32138;
      2: m = 30274;
      3: m = 27246;
      4: m = 23170;
      5: m = 18205;
      6: m = 12540;
      7: m = 6393;
      default: m = 0;
    endcase
    return m;
  endfunction

  function automatic int cos4(int k);
    int m;
    case (k)
      0: m = 46341;
      1: m = 42813;
      2: m = 32768;
      3: m = 17734;
      default: m = 0;
    endcase
    return m;
  endfunction

  // C[u][j]: fold (2j+1)u onto the first quadrant and restore the sign
  function automatic int coef(int n, int u, int j);
    int k;
    bit neg;
    if (u == 0) return (n == 8) ? A0_8 : A0_4;
    k = ((2 * j + 1) * u) % (4 * n);
    if (k > 2 * n) k = 4 * n - k;
    neg = 1'b0;
    if (k > n) begin
      k = 2 * n - k;
      neg = 1'b1;
    end
    k = (n == 8) ? cos8(k) : cos4(k);
    return neg ? -k : k;
  endfunction

  function automatic int acc_w(int dw, int cw, int n);
    return dw + cw + $clog2(n);
  endfunction

endpackage

// File: rtl/dct_dot_n.sv
// dct_dot_n: N-term signed dot product, round half up, reduce to DATA_WIDTH.
// DCT_SATURATE_EN selects clamping (and a sat output) instead of wrapping.
module dct_dot_n
  import dct_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 18
) (
  input  logic [N*COEF_WIDTH-1:0] coef,
  input  logic [N*DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0]   result
`ifdef DCT_SATURATE_EN
  ,
  output logic                    sat
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int AW = acc_w(DW, CW, N);
  localparam int SH = CW - 2;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (CW - 3);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] rnd;

  // full-precision accumulate, then round half up
  always_comb begin
    acc = '0;
    for (int j = 0; j < N; j++)
      acc = acc + AW'($signed(coef[j*CW +: CW]))
                * AW'($signed(data[j*DW +: DW]));
    rnd = (acc + HALF) >>> SH;
  end

`ifdef DCT_SATURATE_EN
  logic [AW-DW:0] hi;

  // clamp when the bits above the sign are not all copies of it
  always_comb begin
    hi  = rnd[AW-1:DW-1];
    sat = !((&hi) || !(|hi));
    if (!sat)
      result = rnd[DW-1:0];
    else if (rnd[AW-1])
      result = {1'b1, {(DW-1){1'b0}}};
    else
      result = {1'b0, {(DW-1){1'b1}}};
  end
`else
  logic unused_hi;

  assign result    = rnd[DW-1:0];
  assign unused_hi = ^rnd[AW-1:DW];
`endif

endmodule

// File: rtl/dct_2d_stream.sv
// dct_2d_stream: row pass -> NxN transpose buffer -> column pass 2D DCT-II.
// Optional macro DCT_SATURATE_EN: clamp instead of wrap, adds sat_flag.
module dct_2d_stream
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int BLOCK_N    = 8,
  parameter int COEF_WIDTH = 18
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BLOCK_N*DATA_WIDTH-1:0] in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BLOCK_N*DATA_WIDTH-1:0] out_row,
  output logic [$clog2(BLOCK_N)-1:0]    out_idx,
  output logic                          busy
`ifdef DCT_SATURATE_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int N  = BLOCK_N;
  localparam int IW = $clog2(N);
  localparam int RW = N * DW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (!(N == 4 || N == 8) || FRAC_BITS >= DW
      || CW - 2 != COEF_FRAC) begin : g_bad_cfg
    $error("dct_2d_stream: unsupported configuration");
  end

  state_t state_q, state_d;
  logic in_ready_d;
  logic [IW-1:0] row_cnt, sel_v;
  logic [RW-1:0] zbuf [N];
  logic [RW-1:0] zrow, yrow;
  logic [N*CW-1:0] cmat [N];
  logic [N*CW-1:0] col_coef;
  logic [RW-1:0] col_data [N];
  logic in_beat, out_beat, last_in, last_out, load_out;

  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;
  assign last_in  = in_beat && (row_cnt == LAST);
  assign last_out = out_beat && (out_idx == LAST);
  assign load_out = last_in || (out_beat && out_idx != LAST);
  assign sel_v    = (state_q == EMIT) ? out_idx + IW'(1) : '0;
  assign col_coef = cmat[sel_v];

  // constant cosine matrix, one packed row per frequency
  always_comb begin
    for (int v = 0; v < N; v++) begin
      cmat[v] = '0;
      for (int j = 0; j < N; j++)
        cmat[v][j*CW +: CW] = CW'(coef(N, v, j));
    end
  end

  // transposed column operands; the last row bypasses the buffer
  always_comb begin
    for (int u = 0; u < N; u++) begin
      col_data[u] = '0;
      for (int i = 0; i < N; i++)
        col_data[u][i*DW +: DW] =
          (state_q == LOAD && i == N - 1) ? zrow[u*DW +: DW]
                                          : zbuf[i][u*DW +: DW];
    end
  end

`ifdef DCT_SATURATE_EN
  logic [N-1:0] row_sat, col_sat;
`endif

  for (genvar u = 0; u < N; u++) begin : g_lane
    dct_dot_n #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) u_row (
      .coef   (cmat[u]),
      .data   (in_row),
      .result (zrow[u*DW +: DW])
`ifdef DCT_SATURATE_EN
      ,
      .sat    (row_sat[u])
`endif
    );
    dct_dot_n #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) u_col (
      .coef   (col_coef),
      .data   (col_data[u]),
      .result (yrow[u*DW +: DW])
`ifdef DCT_SATURATE_EN
      ,
      .sat    (col_sat[u])
`endif
    );
  end

  // next state: fill N rows, then drain N rows
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (last_in) state_d = EMIT;
      EMIT:    if (last_out) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    in_ready_d = (state_d == LOAD);
  end

  // control state, input row counter and busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      in_ready <= 1'b0;
      row_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      if (in_beat) row_cnt <= row_cnt + IW'(1);
      if (in_beat) busy <= 1'b1;
      else if (last_out) busy <= 1'b0;
    end
  end

  // transpose buffer: row pass results by input row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) zbuf[i] <= '0;
    end else if (in_beat) begin
      zbuf[row_cnt] <= zrow;
    end
  end

  // output register, holds while out_ready is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_idx   <= '0;
    end else begin
      if (load_out) out_row <= yrow;
      if (last_in) begin
        out_valid <= 1'b1;
        out_idx   <= '0;
      end else if (last_out) begin
        out_valid <= 1'b0;
      end else if (out_beat) begin
        out_idx   <= out_idx + IW'(1);
      end
    end
  end

`ifdef DCT_SATURATE_EN
  // sticky clip flag, restarted by the first row of a block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_flag <= 1'b0;
    else
      sat_flag <= (sat_flag && !(in_beat && row_cnt == '0))
                | (in_beat && |row_sat)
                | (load_out && |col_sat);
  end
`endif

endmodule
